// File: rtl/kbd_pkg.sv
// Shared definitions for the Colour Genie keystroke injector: key-code field
// layout, sequencer state encoding and the injected-matrix builder.
package kbd_pkg;

    localparam int SHIFT_BIT = 7;
    localparam int PAUSE_BIT = 6;
    localparam int ROW_HI    = 5;
    localparam int ROW_LO    = 3;
    localparam int COL_HI    = 2;
    localparam int COL_LO    = 0;
    localparam int SHIFT_ROW = 7;
    localparam int SHIFT_COL = 0;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE      = 3'd0;
    localparam seq_state_t ST_SHIFT_PRE = 3'd1;
    localparam seq_state_t ST_PRESS     = 3'd2;
    localparam seq_state_t ST_RELEASE   = 3'd3;
    localparam seq_state_t ST_PAUSE     = 3'd4;

    // Row-major 8x8 matrix: [row][column]
    typedef logic [7:0][7:0] kbd_matrix_t;

    function automatic kbd_matrix_t key_matrix(input seq_state_t st, input logic [7:0] code);
        kbd_matrix_t m;
        m = '0;
        case (st)
            ST_SHIFT_PRE: m[SHIFT_ROW][SHIFT_COL] = 1'b1;
            ST_PRESS: begin
                m[code[ROW_HI:ROW_LO]][code[COL_HI:COL_LO]] = 1'b1;
                m[SHIFT_ROW][SHIFT_COL] = m[SHIFT_ROW][SHIFT_COL] | code[SHIFT_BIT];
            end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous 8-bit FIFO with wrap-around pointers, flush and a sticky
// overflow flag; full/empty/overflow are registered.
module kbd_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [AW:0] wr_ptr_s;
    logic [AW:0] rd_ptr_s;
    logic        full_r;
    logic        empty_r;
    logic        overflow_r;
    logic        accept_s;
    logic        drop_s;

    // A pop in the same cycle frees a slot, so a write at full still lands.
    assign accept_s = wr & (~full_r | rd);
    assign drop_s   = wr & full_r & ~rd;
    assign wr_ptr_s = wr_ptr_r + {{AW{1'b0}}, accept_s};
    assign rd_ptr_s = rd_ptr_r + {{AW{1'b0}}, rd};

    // Storage write port
    always_ff @(posedge clock) begin
        if (accept_s && !flush) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    // Pointer and status registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
        end else begin
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            empty_r    <= (wr_ptr_s == rd_ptr_s);
            full_r     <= (wr_ptr_s[AW] != rd_ptr_s[AW]) &&
                          (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]);
            overflow_r <= overflow_r | drop_s;
        end
    end

    assign rdata    = mem_r[rd_ptr_r[AW-1:0]];
    assign full     = full_r;
    assign empty    = empty_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/kbd_inject.sv
// Keystroke injection scheduler: plays queued matrix codes as timed
// press/hold/release sequences and ORs them into the live keyboard byte.
module kbd_inject #(
    parameter int          DEPTH = 16,
    parameter logic [15:0] SETUP = 16'd2,
    parameter logic [15:0] HOLD  = 16'd4,
    parameter logic [15:0] GAP   = 16'd4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       wr,
    input  logic [7:0] wdata,
    input  logic       abort,
    input  logic [7:0] a,
    input  logic [7:0] kq,
    output logic [7:0] q,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow
);

    import kbd_pkg::*;

    seq_state_t  state_r;
    seq_state_t  state_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_s;
    logic [7:0]  code_r;
    logic [7:0]  code_s;
    kbd_matrix_t inj_r;
    kbd_matrix_t inj_s;
    logic        busy_r;
    logic        pop_s;
    logic [7:0]  head_s;
    logic        fifo_empty_s;
    logic [7:0]  q_s;

    kbd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (abort),
        .wr       (wr & ~abort),
        .rd       (pop_s),
        .wdata    (wdata),
        .rdata    (head_s),
        .full     (full),
        .empty    (fifo_empty_s),
        .overflow (overflow)
    );

    // Sequencer next-state: every transition waits for the ce tick on which the counter is 0
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        code_s  = code_r;
        pop_s   = 1'b0;
        if (ce) begin
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        pop_s  = 1'b1;
                        code_s = head_s;
                        if (head_s[PAUSE_BIT]) begin
                            state_s = ST_PAUSE;
                            cnt_s   = HOLD + GAP;
                        end else if (head_s[SHIFT_BIT]) begin
                            state_s = ST_SHIFT_PRE;
                            cnt_s   = SETUP;
                        end else begin
                            state_s = ST_PRESS;
                            cnt_s   = HOLD;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SHIFT_PRE: begin
                    if (cnt_r == 16'd0) begin
                        state_s = ST_PRESS;
                        cnt_s   = HOLD;
                    end else begin
                        cnt_s = cnt_r - 16'd1;
                    end
                end
                ST_PRESS: begin
                    if (cnt_r == 16'd0) begin
                        state_s = ST_RELEASE;
                        cnt_s   = GAP;
                    end else begin
                        cnt_s = cnt_r - 16'd1;
                    end
                end
                ST_RELEASE, ST_PAUSE: begin
                    if (cnt_r == 16'd0) begin
                        state_s = ST_IDLE;
                    end else begin
                        cnt_s = cnt_r - 16'd1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 16'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
        inj_s = key_matrix(state_s, code_s);
    end

    // Sequencer, code and injected-matrix registers; abort drops everything at once
    always_ff @(posedge clock) begin
        if (!reset_n || abort) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
            code_r  <= 8'd0;
            inj_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            code_r  <= code_s;
            inj_r   <= inj_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // Merge: selected rows of the injected matrix OR onto the live column byte
    always_comb begin
        q_s = kq;
        for (int r = 0; r < 8; r++) begin
            q_s = q_s | (inj_r[r] & {8{a[r]}});
        end
    end

    assign q     = q_s;
    assign empty = fifo_empty_s;
    assign busy  = busy_r;

endmodule

// File: tb/tb_kbd_inject.sv
// Self-checking bench for kbd_inject: directed scenarios plus randomized
// traffic against a per-tick queue model of the injected matrix.
module tb_kbd_inject;

    localparam int DEPTH = 16;
    localparam int SETUP = 2;
    localparam int HOLD  = 4;
    localparam int GAP   = 4;

    logic       clock = 1'b0;
    logic       reset_n, ce, wr, abort;
    logic [7:0] wdata, a, kq, q;
    logic       full, empty, busy, overflow;

    always #5 clock = ~clock;

    kbd_inject #(.DEPTH(DEPTH), .SETUP(16'd2), .HOLD(16'd4), .GAP(16'd4)) dut (
        .clock(clock), .reset_n(reset_n), .ce(ce), .wr(wr), .wdata(wdata),
        .abort(abort), .a(a), .kq(kq), .q(q), .full(full), .empty(empty),
        .busy(busy), .overflow(overflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Reference model: queued codes, plus one matrix entry per remaining ce tick
    logic [7:0]  m_codes[$];
    logic [63:0] m_ticks[$];
    logic        m_ovf = 1'b0;

    function automatic logic [7:0] m_q(input logic [7:0] av, input logic [7:0] kv);
        logic [63:0] inj;
        logic [7:0]  r;
        inj = (m_ticks.size() > 0) ? m_ticks[0] : 64'd0;
        r = kv;
        for (int i = 0; i < 8; i++) if (av[i]) r = r | inj[i*8 +: 8];
        return r;
    endfunction

    task automatic m_expand(input logic [7:0] code);
        logic [63:0] sh, key;
        sh  = 64'd1 << (7 * 8 + 0);
        key = 64'd1 << (int'(code[5:3]) * 8 + int'(code[2:0]));
        if (code[6]) begin
            for (int i = 0; i < HOLD + GAP + 1; i++) m_ticks.push_back(64'd0);
        end else begin
            if (code[7]) for (int i = 0; i < SETUP + 1; i++) m_ticks.push_back(sh);
            for (int i = 0; i < HOLD + 1; i++) m_ticks.push_back(code[7] ? (key | sh) : key);
            for (int i = 0; i < GAP + 1; i++) m_ticks.push_back(64'd0);
        end
    endtask

    task automatic m_edge(input logic rn, input logic w, input logic [7:0] d,
                          input logic c, input logic ab);
        if (!rn || ab) begin
            m_codes.delete();
            m_ticks.delete();
            if (!rn) m_ovf = 1'b0;
        end else begin
            if (c) begin
                if (m_ticks.size() == 0) begin
                    if (m_codes.size() > 0) m_expand(m_codes.pop_front());
                end else begin
                    void'(m_ticks.pop_front());
                end
            end
            if (w) begin
                if (m_codes.size() < DEPTH) m_codes.push_back(d);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic c,
                        input logic ab, input string tag);
        wr = w; wdata = d; ce = c; abort = ab;
        @(posedge clock);
        m_edge(reset_n, w, d, c, ab);
        #1;
        wr = 1'b0; abort = 1'b0;
        chk({tag, ".q"},     q,               m_q(a, kq));
        chk({tag, ".full"},  {7'd0, full},    {7'd0, m_codes.size() == DEPTH});
        chk({tag, ".empty"}, {7'd0, empty},   {7'd0, m_codes.size() == 0});
        chk({tag, ".busy"},  {7'd0, busy},    {7'd0, m_ticks.size() != 0});
        chk({tag, ".ovf"},   {7'd0, overflow}, {7'd0, m_ovf});
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && (busy || !empty); i++) step(1'b0, 8'd0, 1'b1, 1'b0, tag);
        chk({tag, "_idle"}, {7'd0, busy | ~empty}, 8'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nk, ng, n1, n3, d0, d1, leak;
        logic seen;
        reset_n = 1'b0; ce = 1'b0; wr = 1'b0; abort = 1'b0;
        wdata = 8'd0; a = 8'd0; kq = 8'd0;
        step(1'b0, 8'd0, 1'b0, 1'b0, "rst");
        step(1'b0, 8'd0, 1'b0, 1'b0, "rst");
        reset_n = 1'b1;

        // Plain key A: 5 ticks pressed, 5 ticks gap
        a = 8'h01; kq = 8'h00;
        nk = 0; ng = 0; d0 = 0; seen = 1'b0;
        step(1'b1, 8'h01, 1'b1, 1'b0, "t1w");
        for (int i = 1; i < 40; i++) begin
            step(1'b0, 8'd0, 1'b1, 1'b0, "t1");
            if (q == 8'h02) begin
                if (nk == 0) d0 = i;
                nk++;
            end else if (busy) ng++;
            if (nk > 0 && !busy) break;
        end
        chk("t1_key_ticks", 8'(nk), 8'd5);
        chk("t1_gap_ticks", 8'(ng), 8'd5);

        // ModSel with Shift
        a = 8'h80; n1 = 0; n3 = 0;
        step(1'b1, 8'hB9, 1'b1, 1'b0, "t2w");
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 8'd0, 1'b1, 1'b0, "t2");
            if (q == 8'h01) n1++;
            if (q == 8'h03) n3++;
            if ((n1 + n3) > 0 && !busy) break;
        end
        chk("t2_shift_ticks", 8'(n1), 8'd3);
        chk("t2_key_ticks",   8'(n3), 8'd5);

        // Fill with ce held low, overflow on the 17th write, replay
        a = 8'hFF;
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'($urandom) & 8'hBF, 1'b0, 1'b0, "t3w");
            if (i == 14) chk("t3_not_full_15", {7'd0, full}, 8'd0);
            if (i == 15) chk("t3_full_16", {7'd0, full}, 8'd1);
        end
        chk("t3_overflow", {7'd0, overflow}, 8'd1);
        drain("t3_replay");

        // Live and injected keys are both visible
        a = 8'h01; kq = 8'h10;
        step(1'b1, 8'h01, 1'b1, 1'b0, "t4w");
        for (int i = 0; i < 10 && q == kq; i++) step(1'b0, 8'd0, 1'b1, 1'b0, "t4");
        chk("t4_merge", q, 8'h12);
        drain("t4_drain");

        // Abort during PRESS with 3 codes queued
        a = 8'hFF; kq = 8'h24;
        step(1'b1, 8'h01, 1'b0, 1'b0, "t5w");
        step(1'b1, 8'h0A, 1'b0, 1'b0, "t5w");
        step(1'b1, 8'h13, 1'b0, 1'b0, "t5w");
        step(1'b1, 8'h1C, 1'b0, 1'b0, "t5w");
        for (int i = 0; i < 10 && q == kq; i++) step(1'b0, 8'd0, 1'b1, 1'b0, "t5");
        step(1'b0, 8'd0, 1'b1, 1'b1, "t5a");
        chk("t5_q_live",  q, kq);
        chk("t5_empty",   {7'd0, empty}, 8'd1);
        chk("t5_busy",    {7'd0, busy}, 8'd0);
        leak = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'd0, 1'b1, 1'b0, "t5p");
            if (q != kq) leak++;
        end
        chk("t5_no_inject", 8'(leak), 8'd0);

        // Pause token delays the key by HOLD+GAP+1 ticks
        a = 8'h01; kq = 8'h00; d1 = 0;
        step(1'b1, 8'h40, 1'b1, 1'b0, "t6w");
        step(1'b1, 8'h01, 1'b1, 1'b0, "t6w");
        for (int i = 1; i < 40; i++) begin
            step(1'b0, 8'd0, 1'b1, 1'b0, "t6");
            if (q == 8'h02) begin
                d1 = i;
                break;
            end
        end
        chk("t6_pause_delay", 8'(d1 - d0), 8'(HOLD + GAP + 1));
        step(1'b1, 8'h09, 1'b1, 1'b0, "t6x");
        kq = 8'h5A;
        reset_n = 1'b0;
        step(1'b0, 8'd0, 1'b1, 1'b0, "t6r");
        chk("t6_rst_q",     q, 8'h5A);
        chk("t6_rst_full",  {7'd0, full}, 8'd0);
        chk("t6_rst_empty", {7'd0, empty}, 8'd1);
        chk("t6_rst_busy",  {7'd0, busy}, 8'd0);
        chk("t6_rst_ovf",   {7'd0, overflow}, 8'd0);
        reset_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            a  = 8'($urandom);
            kq = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 199) == 0, "rnd");
            a  = 8'($urandom);
            kq = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'h00;
            #1;
            chk("rnd_comb_q", q, m_q(a, kq));
        end
        drain("rnd_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
